// File: rtl/resp_sig_compactor_pkg.sv
// Shared constants, FSM state type and MISR step function for resp_sig_compactor.
package resp_sig_pkg;

  localparam int              SIG_W = 16;
  localparam logic [SIG_W-1:0] SEED  = 16'hFFFF;
  localparam logic [SIG_W-1:0] POLY  = 16'h1021;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One MISR clock: CRC-style shift/feedback, then fold the 3 response bits into the LSBs.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [2:0]       d);
    return ({s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0)) ^ {{(SIG_W-3){1'b0}}, d};
  endfunction

endpackage

// File: rtl/resp_sig_compactor_if.sv
// Handshake/result bundle for resp_sig_compactor. Golden/pass exist only with RESP_SIG_GOLDEN_EN.
interface resp_sig_compactor_if
  import resp_sig_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             o;
  logic             p;
  logic             q;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] vec_cnt;
`ifdef RESP_SIG_GOLDEN_EN
  logic [SIG_W-1:0] golden;
  logic             pass;
`endif

  modport master (
    output start, len, in_valid, o, p, q,
`ifdef RESP_SIG_GOLDEN_EN
    output golden,
    input  pass,
`endif
    input  in_ready, busy, done, signature, vec_cnt
  );

  modport slave (
    input  start, len, in_valid, o, p, q,
`ifdef RESP_SIG_GOLDEN_EN
    input  golden,
    output pass,
`endif
    output in_ready, busy, done, signature, vec_cnt
  );

endinterface

// File: rtl/resp_sig_compactor_misr.sv
// 16-bit MISR register: load to SEED has priority over an update step.
module misr16
  import resp_sig_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [2:0]       data,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      sig <= '0;
    else if (load) sig <= SEED;
    else if (en)   sig <= misr_step(sig, data);
  end

endmodule

// File: rtl/resp_sig_compactor.sv
// Response-signature compactor: IDLE/RUN/DONE control around a misr16 instance.
// Optional golden compare (golden input, pass output) enabled by `define RESP_SIG_GOLDEN_EN.
module resp_sig_compactor
  import resp_sig_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  resp_sig_compactor_if.slave  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q;
  logic [CNT_W-1:0] len_q;
  logic             load;
  logic             accept;
  logic [2:0]       data;
  logic [SIG_W-1:0] sig_q;

  assign data = {bus.o, bus.p, bus.q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = (bus.len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        accept = bus.in_valid;
        if (accept && (vec_cnt_q == len_q - CNT_W'(1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // len is captured at start so a change mid-run cannot move the end point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_cnt_q <= '0;
      len_q     <= '0;
    end else if (load) begin
      vec_cnt_q <= '0;
      len_q     <= bus.len;
    end else if (accept) begin
      vec_cnt_q <= vec_cnt_q + CNT_W'(1);
    end
  end

  misr16 u_misr (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .load (load),
    .data (data),
    .sig  (sig_q)
  );

  assign bus.in_ready  = (state_q == RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.signature = sig_q;
  assign bus.vec_cnt   = vec_cnt_q;

`ifdef RESP_SIG_GOLDEN_EN
  // Compare against the value the MISR takes on the DONE-entry edge so pass lines up with done.
  logic [SIG_W-1:0] final_sig;
  logic             pass_q;

  assign final_sig = (state_q == IDLE) ? SEED : misr_step(sig_q, data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      pass_q <= 1'b0;
    else if (state_d == DONE && state_q != DONE)   pass_q <= (final_sig == bus.golden);
    else if (load)                                 pass_q <= 1'b0;
  end

  assign bus.pass = pass_q;
`endif

endmodule

// File: tb/tb_resp_sig_compactor.sv
// Directed bench for resp_sig_compactor with a done-triggered scoreboard of expected signatures.
module tb_resp_sig_compactor;
  import resp_sig_pkg::*;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  resp_sig_compactor_if #(.CNT_W(CNT_W)) bus ();

  resp_sig_compactor #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0]      sig;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;
  logic prev_done = 1'b0;

  function automatic logic [15:0] model_step(logic [15:0] s, logic [2:0] d);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {13'b0, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] s, input logic [CNT_W-1:0] c);
    exp_t e;
    e.sig = s;
    e.cnt = c;
    sb.push_back(e);
    pushed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [2:0] v, input logic vld);
    bus.in_valid = vld;
    {bus.o, bus.p, bus.q} = v;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Completion monitor: every done cycle must be a lone pulse and match the next expected run.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      chk("done_width", {31'b0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        popped++;
        chk("sb_sig", {16'b0, bus.signature}, {16'b0, e.sig});
        chk("sb_cnt", {24'b0, bus.vec_cnt}, {24'b0, e.cnt});
      end
    end
    prev_done = bus.done;
  end

  initial begin
    logic [15:0] s;
    logic [2:0]  v;
    int          n;
    int          vp[7];

    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.o = 1'b0; bus.p = 1'b0; bus.q = 1'b0;
`ifdef RESP_SIG_GOLDEN_EN
    bus.golden = 16'h0000;
`endif

    #3;
    chk("rst_sig",   {16'b0, bus.signature}, 32'h0);
    chk("rst_cnt",   {24'b0, bus.vec_cnt},   32'h0);
    chk("rst_busy",  {31'b0, bus.busy},      32'h0);
    chk("rst_rdy",   {31'b0, bus.in_ready},  32'h0);
    chk("rst_done",  {31'b0, bus.done},      32'h0);
`ifdef RESP_SIG_GOLDEN_EN
    chk("rst_pass",  {31'b0, bus.pass},      32'h0);
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // len=1, vector 000
    do_start(8'd1);
    chk("t1_busy", {31'b0, bus.busy},     32'd1);
    chk("t1_rdy",  {31'b0, bus.in_ready}, 32'd1);
    chk("t1_seed", {16'b0, bus.signature}, 32'hFFFF);
    chk("t1_cnt0", {24'b0, bus.vec_cnt},  32'd0);
    push(16'hEFDF, 8'd1);
    send(3'b000, 1'b1);
    chk("t1_done", {31'b0, bus.done},      32'd1);
    chk("t1_sig",  {16'b0, bus.signature}, 32'hEFDF);
    chk("t1_cnt",  {24'b0, bus.vec_cnt},   32'd1);
    chk("t1_nrdy", {31'b0, bus.in_ready},  32'd0);
    tick();
    chk("t1_done_low", {31'b0, bus.done},      32'd0);
    chk("t1_hold",     {16'b0, bus.signature}, 32'hEFDF);

    // len=1, vector 101
`ifdef RESP_SIG_GOLDEN_EN
    bus.golden = 16'hEFDA;
`endif
    do_start(8'd1);
    push(16'hEFDA, 8'd1);
    send(3'b101, 1'b1);
    chk("t2_sig", {16'b0, bus.signature}, 32'hEFDA);
`ifdef RESP_SIG_GOLDEN_EN
    chk("t2_pass1", {31'b0, bus.pass}, 32'd1);
    tick();
    bus.golden = 16'hEFDF;
    do_start(8'd1);
    push(16'hEFDA, 8'd1);
    send(3'b101, 1'b1);
    chk("t2_pass0", {31'b0, bus.pass}, 32'd0);
`endif
    tick();

    // len=0 goes straight to DONE
    push(16'hFFFF, 8'd0);
    do_start(8'd0);
    chk("t3_done", {31'b0, bus.done},      32'd1);
    chk("t3_rdy",  {31'b0, bus.in_ready},  32'd0);
    chk("t3_sig",  {16'b0, bus.signature}, 32'hFFFF);
    chk("t3_cnt",  {24'b0, bus.vec_cnt},   32'd0);
    tick();
    chk("t3_rdy2", {31'b0, bus.in_ready},  32'd0);
    chk("t3_idle", {31'b0, bus.done},      32'd0);

    // len=4 with gaps in in_valid and a stray start mid-run
    vp = '{1, 0, 0, 1, 1, 0, 1};
    do_start(8'd4);
    s = SEED;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      v = 3'($urandom_range(0, 7));
      if (vp[i] != 0) begin
        s = model_step(s, v);
        n++;
        if (n == 4) push(s, 8'd4);
      end
      if (i == 1) begin
        bus.start = 1'b1;
        bus.len   = 8'd2;
      end
      send(v, vp[i] != 0);
      bus.start = 1'b0;
      chk("t4_sig",  {16'b0, bus.signature}, {16'b0, s});
      chk("t4_cnt",  {24'b0, bus.vec_cnt},   n);
      chk("t4_done", {31'b0, bus.done},      (i == 6) ? 32'd1 : 32'd0);
    end
    tick();

    // reset mid-run discards the partial signature
    do_start(8'd4);
    send(3'($urandom_range(0, 7)), 1'b1);
    send(3'($urandom_range(0, 7)), 1'b1);
    chk("t5_cnt2", {24'b0, bus.vec_cnt}, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_sig0",  {16'b0, bus.signature}, 32'h0);
    chk("t5_cnt0",  {24'b0, bus.vec_cnt},   32'h0);
    chk("t5_busy0", {31'b0, bus.busy},      32'h0);
    chk("t5_rdy0",  {31'b0, bus.in_ready},  32'h0);
    chk("t5_done0", {31'b0, bus.done},      32'h0);
    @(negedge clk);
    rst = 1'b1;
    do_start(8'd1);
    push(16'hEFDF, 8'd1);
    send(3'b000, 1'b1);
    chk("t5_sig",  {16'b0, bus.signature}, 32'hEFDF);
    chk("t5_done", {31'b0, bus.done},      32'd1);
    tick();

    // back-to-back: second start on the cycle right after done
    do_start(8'd2);
    s = model_step(model_step(SEED, 3'b011), 3'b100);
    push(s, 8'd2);
    send(3'b011, 1'b1);
    send(3'b100, 1'b1);
    chk("t6_done_a", {31'b0, bus.done}, 32'd1);
    tick();
    do_start(8'd1);
    chk("t6_busy", {31'b0, bus.busy},      32'd1);
    chk("t6_seed", {16'b0, bus.signature}, 32'hFFFF);
    push(model_step(SEED, 3'b110), 8'd1);
    send(3'b110, 1'b1);
    chk("t6_sig",  {16'b0, bus.signature}, {16'b0, model_step(SEED, 3'b110)});
    tick();
    tick();

    chk("sb_drained", popped, pushed);
    chk("sb_empty",   sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/resp_sig_compactor.md
RESP_SIG_COMPACTOR -- requirements
Module: resp_sig_compactor

Interface
REQ-001 Parameter CNT_W, default 8: width of the vector-length field and vector counter.
REQ-002 Port clk  input  1  sole clock, rising edge.
REQ-003 Port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 Port start  input  1  begin a compaction run; sampled only in IDLE.
REQ-005 Port len  input  CNT_W  number of response vectors to compact; sampled with start.
REQ-006 Port in_valid  input  1  response vector {o,p,q} valid this cycle.
REQ-007 Ports o, p, q  input  1 each  response bits from the upstream logic block under test.
REQ-008 Port in_ready  output  1  block accepts a vector this cycle.
REQ-009 Port busy  output  1  high in RUN.
REQ-010 Port done  output  1  single-cycle completion pulse.
REQ-011 Port signature  output  16  MISR contents, held stable outside RUN.
REQ-012 Port vec_cnt  output  CNT_W  vectors accepted in the current or last run.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE: if start=1 and len!=0, load signature=SEED, clear vec_cnt and go to RUN next cycle.
REQ-015 IDLE: if start=1 and len=0, load signature=SEED, clear vec_cnt and go directly to DONE.
REQ-016 in_ready SHALL equal 1 only in RUN (combinational from state); a vector is accepted when in_valid & in_ready.
REQ-017 On acceptance: signature <= ({sig[14:0],1'b0} ^ (sig[15] ? POLY : 0)) ^ {13'b0,o,p,q}; vec_cnt <= vec_cnt+1.
REQ-018 When a vector is accepted and vec_cnt = len-1, the FSM SHALL enter DONE on that edge; len is latched at start.
REQ-019 If in_valid=0 in RUN, signature and vec_cnt SHALL hold (no timeout).
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 start SHALL be ignored in RUN and DONE; a start in the cycle after DONE (IDLE) SHALL be honoured.
REQ-022 Latency: done is asserted the cycle after the last accepted vector.
REQ-023 signature and vec_cnt SHALL retain final values in IDLE until the next accepted start.

Reset
REQ-024 rst=0 SHALL asynchronously force state=IDLE, signature=16'h0000, vec_cnt=0, done=0, busy=0 and in_ready=0; this applies mid-run, and the partial signature is discarded.
REQ-025 Release of rst is synchronous to clk; the first start is honoured on the first edge with rst=1.

Configuration
REQ-026 Macro RESP_SIG_GOLDEN_EN defined: add input golden[15:0] and output pass (1 bit).
REQ-027 pass SHALL be registered with done as (signature==golden), hold until the next accepted start, and reset to 0.
REQ-028 Macro RESP_SIG_GOLDEN_EN undefined: golden and pass do not exist, and there is no comparison logic.

Structure
REQ-029 Package resp_sig_pkg SHALL hold SIG_W=16, SEED=16'hFFFF, POLY=16'h1021 and the state enum typedef.
REQ-030 The MISR update SHALL be one sub-module, misr16, with inputs en, load and 3-bit data; the FSM and counter stay in the top.

Verification
REQ-031 Reset then start with len=1, one vector {o,p,q}=000 -> signature=16'hEFDF, vec_cnt=1, done pulse of exactly 1 cycle.
REQ-032 start with len=1, vector 101 -> signature=16'hEFDA; with RESP_SIG_GOLDEN_EN and golden=16'hEFDA -> pass=1; with golden=16'hEFDF -> pass=0.
REQ-033 start with len=0 -> done the cycle after start, signature=16'hFFFF, vec_cnt=0, in_ready never 1.
REQ-034 len=4 with in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 updates, done after the 4th, and a start pulsed during RUN is ignored.
REQ-035 rst driven low between edges after 2 of 4 vectors -> outputs zero immediately; a new len=1 run then matches REQ-031.
REQ-036 Back-to-back runs with start on the cycle after done -> second run accepted, and its signature is computed from SEED, not from the prior value.
